instr_exec_unit: RTL
====================

# instr_exec_unit

Downstream consumer of the instruction register. On a start command it walks the register's read pointer over a programmed window of entries, fetches each `instruction_t` word, and executes it. Single-cycle opcodes complete immediately; DIV/MOD use an iterative divider. Each result goes to the result sink through a valid/ready handshake, so the block replaces the testbench's passive read loop with a real execution stage.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: number of iterations of the radix-2 restoring divider, one bit per cycle; fixed at operand width.

Ports (types from `instr_register_pkg`):
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: pulse that begins a run; sampled only in IDLE.
- `start_addr`, input, `address_t` (5): first entry to execute.
- `count`, input, 6: number of entries to execute, 1..32.
- `instruction_word`, input, `instruction_t`: combinational read data from the instruction register at `read_pointer`.
- `read_pointer`, output, `address_t`: read address driven to the instruction register.
- `busy`, output, 1: high from the cycle after an accepted start until the cycle `done` pulses, inclusive.
- `result`, output, signed 64: execution result.
- `result_opc`, output, `opcode_t`: opcode that produced `result`.
- `result_addr`, output, `address_t`: register entry that produced `result`.
- `div_by_zero`, output, 1: qualifies `result`; DIV/MOD with `op_b`=0.
- `result_valid`, output, 1: the `result_*` fields and `div_by_zero` are valid.
- `result_ready`, input, 1: the sink accepts the result.
- `done`, output, 1: one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, FETCH, EXEC, DIV, OUT, DONE.
- IDLE:
  - `start`=1 with `count`≠0: latch `start_addr` into `read_pointer`, latch `count` into the remaining-entries counter, go to FETCH.
  - `start` with `count`=0: ignored; the block stays in IDLE and `busy` stays 0.
- FETCH: register `instruction_word`, then go to EXEC.
- EXEC: compute from the registered word, with operands signed 32-bit:
  - ZERO gives 0. PASSA gives sext(op_a). PASSB gives sext(op_b).
  - ADD gives sext(a)+sext(b). SUB gives sext(a)-sext(b). Both are evaluated in 64 bits, so there is no overflow.
  - MULT gives the full signed 64-bit product.
  - Undefined opcode encodings (8..15) behave as ZERO.
  - Single-cycle opcodes go to OUT.
  - DIV/MOD with b≠0 go to DIV.
  - DIV/MOD with b=0 go to OUT with `result`=0 and `div_by_zero`=1.
- DIV:
  - Runs `DIV_CYCLES` iterations on |a| and |b|, then applies signs and goes to OUT.
  - DIV truncates toward zero; the quotient is sign-extended to 64 bits.
  - MOD remainder takes the sign of the dividend; the remainder is sign-extended.
  - The special case a=-2^31, b=-1 gives +2^31 (fits in 64 bits).
- OUT:
  - `result_valid`=1, and all `result_*` fields are held stable until `result_valid`&&`result_ready`.
  - On that handshake, decrement the remaining-entries counter.
  - If entries remain: `read_pointer` ← `read_pointer`+1, wrapping 31→0, and go to FETCH.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` while `busy` is ignored.
- `reset` in any state:
  - Next state is IDLE and the divider and counters are cleared.
  - Any in-flight result is discarded; no `done` is produced.
  - Reset values: `read_pointer`=0, `busy`=0, `result`=0, `result_opc`=ZERO, `result_addr`=0, `div_by_zero`=0, `result_valid`=0, `done`=0.
- `result` is registered and is 0 whenever `result_valid`=0.

## Timing
- Start is sampled at edge t.
- FETCH in cycle t+1: `read_pointer`=`start_addr`, `busy`=1.
- EXEC in cycle t+2.
- Single-cycle opcode: `result_valid` first rises in cycle t+3.
- DIV/MOD: `result_valid` first rises in cycle t+3+`DIV_CYCLES` (t+35).
- Divide-by-zero: `result_valid` rises in cycle t+3, the same as a single-cycle opcode.
- Handshake at edge h with entries remaining: next FETCH in cycle h+1; per-entry throughput is 3 cycles (single-cycle) or 35 cycles (DIV/MOD) with `result_ready` tied high.
- Last handshake at edge h: `done` is high in cycle h+1, `busy` drops at h+2, and a new start is accepted from h+2.
- `result_ready` low stalls indefinitely in OUT with no change to outputs.
- `read_pointer` changes only on FETCH entry, and is stable from FETCH through OUT.

## Test plan
- Reset, then idle with `count`=0 and `start` pulsed: all outputs stay at their reset values and `busy` stays 0.
- Entry 0 = ADD a=5, b=-7, `start_addr`=0, `count`=1, `result_ready`=1: `result`=-2, `result_addr`=0, `result_valid` at t+3, `done` at t+4.
- Window of 3 entries, `start_addr`=30, `count`=3, holding MULT 0x7FFFFFFF×0x7FFFFFFF, SUB a=-2^31 b=1, PASSB b=-1:
  - `read_pointer` sequence is 30, 31, 0.
  - Results are 0x3FFFFFFF00000001, -2147483649, -1.
- DIV a=-7 b=2 gives -3 (valid at t+35). MOD a=-7 b=2 gives -1. DIV a=7 b=0 gives 0 with `div_by_zero`=1 at t+3.
- Hold `result_ready`=0 for 10 cycles in OUT: `result` and `result_addr` are held and `result_valid` stays high. Releasing it gives exactly one handshake.
- Assert `reset` in the middle of a DIV iteration:
  - Next cycle is IDLE with all outputs at reset values and no `done` produced.
  - A new start then runs normally.

Source files
------------

// File: rtl/instr_exec_unit.sv
// Execution stage for the instruction register: walks a window of entries,
// executes each word (iterative restoring divider for DIV/MOD) and hands results to a valid/ready sink.

package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  address_t           start_addr,
  input  logic [5:0]         count,
  input  instruction_t       instruction_word,
  output address_t           read_pointer,
  output logic               busy,
  output logic signed [63:0] result,
  output opcode_t            result_opc,
  output address_t           result_addr,
  output logic               div_by_zero,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DIV,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  state_t       state;
  instruction_t instr;
  logic [5:0]   remaining;
  logic [5:0]   div_cnt;
  logic [31:0]  quot;
  logic [31:0]  rem;
  logic [31:0]  divisor;
  logic         neg_q;
  logic         neg_r;
  logic         is_mod;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] exec_result;
  logic [31:0]        a_abs;
  logic [31:0]        b_abs;
  logic               is_divide;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] rem_n;
  logic [31:0] quot_n;
  logic [63:0] q64;
  logic [63:0] r64;
  logic [63:0] div_result;

  // Single-cycle datapath, evaluated from the word latched in FETCH
  always_comb begin
    a_ext     = {{32{instr.op_a[31]}}, instr.op_a};
    b_ext     = {{32{instr.op_b[31]}}, instr.op_b};
    a_abs     = instr.op_a[31] ? 32'(-instr.op_a) : 32'(instr.op_a);
    b_abs     = instr.op_b[31] ? 32'(-instr.op_b) : 32'(instr.op_b);
    is_divide = (instr.opc == DIV) || (instr.opc == MOD);
    case (instr.opc)
      PASSA:   exec_result = a_ext;
      PASSB:   exec_result = b_ext;
      ADD:     exec_result = a_ext + b_ext;
      SUB:     exec_result = a_ext - b_ext;
      MULT:    exec_result = a_ext * b_ext;
      default: exec_result = 64'sd0;
    endcase
  end

  // One restoring step per cycle on magnitudes; |-2^31| = 2^31 fits unsigned
  always_comb begin
    rem_shift = {rem, quot[31]};
    diff      = rem_shift - {1'b0, divisor};
    if (!diff[32]) begin
      rem_n  = diff[31:0];
      quot_n = {quot[30:0], 1'b1};
    end else begin
      rem_n  = rem_shift[31:0];
      quot_n = {quot[30:0], 1'b0};
    end
    q64 = {32'd0, quot_n};
    r64 = {32'd0, rem_n};
    if (is_mod)
      div_result = neg_r ? -r64 : r64;
    else
      div_result = neg_q ? -q64 : q64;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      instr        <= '0;
      remaining    <= '0;
      div_cnt      <= '0;
      quot         <= '0;
      rem          <= '0;
      divisor      <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      is_mod       <= 1'b0;
      read_pointer <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_opc   <= ZERO;
      result_addr  <= '0;
      div_by_zero  <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && (count != 6'd0)) begin
            read_pointer <= start_addr;
            remaining    <= count;
            busy         <= 1'b1;
            state        <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          instr <= instruction_word;
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          result_opc  <= instr.opc;
          result_addr <= read_pointer;
          if (is_divide && (instr.op_b == 32'sd0)) begin
            result       <= '0;
            div_by_zero  <= 1'b1;
            result_valid <= 1'b1;
            state        <= ST_OUT;
          end else if (is_divide) begin
            quot    <= a_abs;
            rem     <= '0;
            divisor <= b_abs;
            neg_q   <= instr.op_a[31] ^ instr.op_b[31];
            neg_r   <= instr.op_a[31];
            is_mod  <= (instr.opc == MOD);
            div_cnt <= '0;
            state   <= ST_DIV;
          end else begin
            result       <= exec_result;
            div_by_zero  <= 1'b0;
            result_valid <= 1'b1;
            state        <= ST_OUT;
          end
        end

        ST_DIV: begin
          quot    <= quot_n;
          rem     <= rem_n;
          div_cnt <= div_cnt + 6'd1;
          // Final iteration folds in the sign correction so OUT follows immediately
          if (div_cnt == DIV_LAST) begin
            result       <= div_result;
            div_by_zero  <= 1'b0;
            result_valid <= 1'b1;
            state        <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            result       <= '0;
            div_by_zero  <= 1'b0;
            remaining    <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              read_pointer <= read_pointer + 5'd1;
              state        <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
